// File: rtl/debounce_pkg.sv
// Purpose: shared constants for the debounce_sync block (FSM encodings, default sizing).
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents:
//   SYNC_STAGES_DEF, STABLE_CYCLES_DEF : default parameter values for debounce_sync
//   ST_LOW, ST_CHK_HI, ST_HIGH, ST_CHK_LO : 2-bit FSM state encodings
package debounce_pkg;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int STABLE_CYCLES_DEF = 4;

  // Plain logic constants rather than an enum so the encoding stays fixed
  // and visible to anything that snoops the state register.
  localparam logic [1:0] ST_LOW    = 2'd0;
  localparam logic [1:0] ST_CHK_HI = 2'd1;
  localparam logic [1:0] ST_HIGH   = 2'd2;
  localparam logic [1:0] ST_CHK_LO = 2'd3;

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Purpose: multi-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: SYNC_STAGES clk edges from d to q.
// Backpressure: none; free-running shift every edge.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset, clears every stage to 0
//   d   : raw asynchronous input (feeds the first flop directly, no logic in front)
//   q   : synchronized level (last stage)
module sync_chain
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Purpose: debounce a bouncy asynchronous level into a clean level plus rise/fall strobes.
// Latency: din stable before edge E0 -> dout/strobe update at edge E0+SYNC_STAGES+1+STABLE_CYCLES.
// Backpressure: none; input is sampled every edge, outputs are free-running registers.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, clears synchronizer, FSM, counter and outputs
//   din  : raw asynchronous level
//   dout : debounced level (registered)
//   rise : one-cycle strobe in the first cycle dout shows 1 (registered)
//   fall : one-cycle strobe in the first cycle dout shows 0 (registered)
//   busy : high while a candidate level change is being qualified (registered)
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din),
    .q  (s)
  );

  // Next-state logic. A disagreeing sample moves into a CHK_* state; the
  // candidate is accepted only after it has been seen on STABLE_CYCLES+1
  // consecutive samples. Any bounce drops straight back to the stable state,
  // so the next disagreeing sample restarts the count from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = ST_CHK_HI;
          cnt_d   = '0;
        end
      end
      ST_CHK_HI: begin
        if (!s) begin
          state_d = ST_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = ST_CHK_LO;
          cnt_d   = '0;
        end
      end
      ST_CHK_LO: begin
        if (s) begin
          state_d = ST_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the current state, so they trail the state
  // register by one edge. The accepted level is 1 in HIGH and while a fall is
  // still being qualified; strobes fire on the edge the registered level flips.
  always_comb begin
    dout_d = (state_q == ST_HIGH) || (state_q == ST_CHK_LO);
    busy_d = (state_q == ST_CHK_HI) || (state_q == ST_CHK_LO);
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Purpose: self-checking bench for debounce_sync, default sizing and STABLE_CYCLES=1 side by side.
// Latency: n/a.
// Backpressure: n/a.
module tb_debounce_sync;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic dout0, rise0, fall0, busy0;
  logic dout1, rise1, fall1, busy1;

  debounce_sync #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .din(din),
    .dout(dout0), .rise(rise0), .fall(fall0), .busy(busy0)
  );

  debounce_sync #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .din(din),
    .dout(dout1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  // Reference model: the synchronized sample is din delayed SYNC edges. The
  // accepted level flips once STABLE+1 consecutive samples disagree with it;
  // an agreeing sample resets that run. Outputs appear one edge after the
  // model's internal decision.
  int   stab [2] = '{4, 1};
  logic sh   [2][SYNC];
  logic lvl  [2];
  int   run  [2];
  logic e_dout [2];
  logic e_rise [2];
  logic e_fall [2];
  logic e_busy [2];
  logic ms;

  always @(posedge clk) begin
    cyc++;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int i = 0; i < SYNC; i++) sh[m][i] = 1'b0;
        lvl[m]    = 1'b0;
        run[m]    = 0;
        e_dout[m] = 1'b0;
        e_rise[m] = 1'b0;
        e_fall[m] = 1'b0;
        e_busy[m] = 1'b0;
      end else begin
        ms = sh[m][SYNC-1];
        e_rise[m] = lvl[m] & ~e_dout[m];
        e_fall[m] = ~lvl[m] & e_dout[m];
        e_dout[m] = lvl[m];
        e_busy[m] = (run[m] > 0);
        if (ms != lvl[m]) begin
          run[m]++;
          if (run[m] == stab[m] + 1) begin
            lvl[m] = ms;
            run[m] = 0;
          end
        end else begin
          run[m] = 0;
        end
        for (int i = SYNC - 1; i > 0; i--) sh[m][i] = sh[m][i-1];
        sh[m][0] = din;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("m_dout_s4", dout0, e_dout[0]);
      chk("m_rise_s4", rise0, e_rise[0]);
      chk("m_fall_s4", fall0, e_fall[0]);
      chk("m_busy_s4", busy0, e_busy[0]);
      chk("m_dout_s1", dout1, e_dout[1]);
      chk("m_rise_s1", rise1, e_rise[1]);
      chk("m_fall_s1", fall1, e_fall[1]);
      chk("m_busy_s1", busy1, e_busy[1]);
    end
  end

  // Advance to 1ns after edge n; inputs set afterwards land before edge n+1.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b1;

    // Reset with din held high: everything stays 0.
    goto(1);
    chk("rst_dout", dout0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    goto(2);
    chk("rst_rise", rise0, 1'b0);
    chk("rst_dout_s1", dout1, 1'b0);
    rst = 1'b0;                      // first live edge E0 = 3

    // din=1 at release: full latency and a rise pulse.
    goto(6);
    chk("rel_busy_e6", busy0, 1'b1);
    chk("rel_s1_dout_e6", dout1, 1'b0);
    goto(7);
    chk("rel_s1_dout_e7", dout1, 1'b1);
    chk("rel_s1_rise_e7", rise1, 1'b1);
    goto(9);
    chk("rel_dout_e9", dout0, 1'b0);
    goto(10);
    chk("rel_dout_e10", dout0, 1'b1);
    chk("rel_rise_e10", rise0, 1'b1);
    goto(11);
    chk("rel_rise_e11", rise0, 1'b0);

    // Clean fall from HIGH, E0 = 13.
    goto(12);
    din = 1'b0;
    goto(16);
    chk("fall_busy_e16", busy0, 1'b1);
    goto(19);
    chk("fall_dout_e19", dout0, 1'b1);
    goto(20);
    chk("fall_dout_e20", dout0, 1'b0);
    chk("fall_pulse_e20", fall0, 1'b1);
    goto(21);
    chk("fall_pulse_e21", fall0, 1'b0);
    chk("fall_busy_e21", busy0, 1'b0);

    // Short pulse: three cycles high, rejected by the default instance.
    goto(25);
    din = 1'b1;
    goto(28);
    din = 1'b0;
    goto(30);
    chk("bounce_busy_e30", busy0, 1'b1);
    goto(40);
    chk("bounce_dout_e40", dout0, 1'b0);
    chk("bounce_busy_e40", busy0, 1'b0);

    // Bouncy press 1,0,1,0,1 then hold; final 0->1 lands before edge 45.
    din = 1'b1;
    goto(41);
    din = 1'b0;
    goto(42);
    din = 1'b1;
    goto(43);
    din = 1'b0;
    goto(44);
    din = 1'b1;
    goto(51);
    chk("press_dout_e51", dout0, 1'b0);
    chk("press_rise_e51", rise0, 1'b0);
    goto(52);
    chk("press_dout_e52", dout0, 1'b1);
    chk("press_rise_e52", rise0, 1'b1);
    goto(53);
    chk("press_rise_e53", rise0, 1'b0);

    // Reset from HIGH: no fall pulse on the reset edge.
    goto(59);
    din = 1'b0;
    rst = 1'b1;
    goto(60);
    chk("rsth_dout_e60", dout0, 1'b0);
    chk("rsth_fall_e60", fall0, 1'b0);
    goto(61);
    rst = 1'b0;
    din = 1'b1;                      // E0 = 62, CHK_HI with cnt=2 after edge 66
    goto(66);
    chk("rstq_busy_e66", busy0, 1'b1);
    rst = 1'b1;
    goto(67);
    chk("rstq_busy_e67", busy0, 1'b0);
    chk("rstq_dout_e67", dout0, 1'b0);
    chk("rstq_rise_e67", rise0, 1'b0);
    rst = 1'b0;                      // E0 = 68
    goto(74);
    chk("rstq_dout_e74", dout0, 1'b0);
    goto(75);
    chk("rstq_dout_e75", dout0, 1'b1);
    chk("rstq_rise_e75", rise0, 1'b1);

    goto(80);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
